// File: rtl/data_mem_access_unit_pkg.sv
// Shared definitions for the data memory access unit: RV32I funct3 codes,
// FSM state encoding, byte-enable constants and store-lane helpers.
package data_mem_access_unit_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_t;

    // Load and store share codes 000/001/010; 100/101 exist only for loads.
    function automatic logic access_fault(input logic       is_store,
                                          input logic [2:0] f3,
                                          input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        case (f3)
            F3_LB:   bad = 1'b0;
            F3_LH:   bad = addr_lo[0];
            F3_LW:   bad = |addr_lo;
            F3_LBU:  bad = is_store;
            F3_LHU:  bad = is_store | addr_lo[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic [3:0] be;
        case (size)
            2'b00:   be = BE_BYTE << addr_lo;
            2'b01:   be = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
            default: be = BE_WORD;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0]  size,
                                               input logic [31:0] wd);
        logic [31:0] d;
        case (size)
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/load_extend_unit.sv
// Selects the addressed byte/halfword of a bus read word and sign- or
// zero-extends it according to the load funct3.
module load_extend_unit
    import data_mem_access_unit_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addr_lo)
            2'b00:   w_byte = i_rdata[7:0];
            2'b01:   w_byte = i_rdata[15:8];
            2'b10:   w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_funct3)
            F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_data = {{16{w_half[15]}}, w_half};
            F3_LBU:  o_data = {24'b0, w_byte};
            F3_LHU:  o_data = {16'b0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/data_mem_access_unit.sv
// MEM-stage data memory access unit: checks alignment/funct3, runs one bus
// transfer per load/store with timeout, and returns the extended load result.
module data_mem_access_unit
    import data_mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Mem_Read_i,
    input  logic        Mem_Write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] Address_i,
    input  logic [31:0] Write_Data_i,
    output logic [31:0] Read_Data_o,
    output logic        Stall_o,
    output logic        Access_Fault_o,
    output logic        Bus_Error_o,
    output logic        Bus_Req_o,
    output logic        Bus_We_o,
    output logic [31:0] Bus_Addr_o,
    output logic [31:0] Bus_Wdata_o,
    output logic [3:0]  Bus_Be_o,
    input  logic        Bus_Ack_i,
    input  logic [31:0] Bus_Rdata_i
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_addr_lo;
    logic [2:0]        r_funct3;
    logic [31:0]       r_read_data;
    logic              r_bus_req;
    logic              r_bus_we;
    logic [31:0]       r_bus_addr;
    logic [31:0]       r_bus_wdata;
    logic [3:0]        r_bus_be;
    logic              r_bus_error;

    logic              w_access;
    logic              w_bad;
    logic              w_idle;
    logic              w_fault;
    logic              w_start;
    logic [31:0]       w_load_data;

    // A simultaneous read+write request is a store, so Mem_Write_i selects.
    assign w_access = Mem_Read_i | Mem_Write_i;
    assign w_bad    = access_fault(Mem_Write_i, funct3_i, Address_i[1:0]);
    assign w_idle   = (r_state == ST_IDLE);
    assign w_fault  = w_idle & w_access & w_bad;
    assign w_start  = w_idle & w_access & ~w_bad;

    load_extend_unit u_load_extend (
        .i_rdata   (Bus_Rdata_i),
        .i_addr_lo (r_addr_lo),
        .i_funct3  (r_funct3),
        .o_data    (w_load_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_addr_lo   <= '0;
            r_funct3    <= '0;
            r_read_data <= '0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_be    <= BE_NONE;
            r_bus_error <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_bus_error <= 1'b0;
                    if (w_start) begin
                        r_state     <= ST_ACCESS;
                        r_cnt       <= '0;
                        r_addr_lo   <= Address_i[1:0];
                        r_funct3    <= funct3_i;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= Mem_Write_i;
                        r_bus_addr  <= {Address_i[31:2], 2'b00};
                        r_bus_wdata <= lane_wdata(funct3_i[1:0], Write_Data_i);
                        r_bus_be    <= lane_be(funct3_i[1:0], Address_i[1:0]);
                    end else if (w_fault && !Mem_Write_i) begin
                        r_read_data <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (Bus_Ack_i) begin
                        r_state   <= ST_DONE;
                        r_bus_req <= 1'b0;
                        if (!r_bus_we) r_read_data <= w_load_data;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state     <= ST_DONE;
                        r_bus_req   <= 1'b0;
                        r_bus_error <= 1'b1;
                        if (!r_bus_we) r_read_data <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                // DONE lets the pipe advance once; inputs still hold the old instruction.
                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    r_bus_error <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign Stall_o        = reset & (w_start | (r_state == ST_ACCESS));
    assign Access_Fault_o = w_fault;
    assign Read_Data_o    = r_read_data;
    assign Bus_Error_o    = r_bus_error;
    assign Bus_Req_o      = r_bus_req;
    assign Bus_We_o       = r_bus_we;
    assign Bus_Addr_o     = r_bus_addr;
    assign Bus_Wdata_o    = r_bus_wdata;
    assign Bus_Be_o       = r_bus_be;

endmodule
